// File: rtl/ppu_dump_pkg.sv
// Shared types and constants for the memory dump reader.
package ppu_dump_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned MEM_BYTES  = 512;
    localparam int unsigned ADDR_W     = 9;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapt,
        StOut,
        StDone
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// Shifts bytes in one at a time; after WORD_BYTES captures the first byte sits in the MSBs.
module byte_packer
    import ppu_dump_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    capture,
    input  logic [7:0]              data,
    output logic [8*WORD_BYTES-1:0] word
);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            word <= '0;
        end else if (capture) begin
            word <= {word[8*WORD_BYTES-9:0], data};
        end
    end

endmodule

// File: rtl/mem_dump_reader.sv
// Walks a word-aligned byte range of a synchronous memory and streams big-endian words out.
module mem_dump_reader #(
    parameter int unsigned ADDR_W    = ppu_dump_pkg::ADDR_W,
    parameter int unsigned MEM_BYTES = ppu_dump_pkg::MEM_BYTES,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr
);
    import ppu_dump_pkg::*;

    // Wide enough that base + 4*count can never wrap back into range.
    localparam int unsigned RangeW = ADDR_W + CNT_W + 2;

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [1:0]        k_q;
    logic [RangeW-1:0] range_end;
    logic              bad_req;
    logic              accept;
    logic              capture;

    assign range_end = RangeW'(start_addr) + (RangeW'(word_count) << 2);
    assign bad_req   = (start_addr[1:0] != 2'b00) || (range_end > RangeW'(MEM_BYTES));
    assign accept    = (state_q == StIdle) && start && !bad_req && (word_count != '0);
    // Read data lags the address by one cycle, so byte k-1 lands while k is issued.
    assign capture   = ((state_q == StRead) && (k_q != 2'd0)) || (state_q == StCapt);
    assign out_addr  = base_q;

    byte_packer u_byte_packer (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .capture (capture),
        .data    (mem_rdata),
        .word    (out_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            base_q      <= '0;
            remaining_q <= '0;
            k_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            out_valid   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (bad_req) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                        end else if (word_count == '0) begin
                            error <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            error       <= 1'b0;
                            base_q      <= start_addr;
                            remaining_q <= word_count;
                            k_q         <= 2'd0;
                            mem_en      <= 1'b1;
                            mem_addr    <= start_addr;
                            busy        <= 1'b1;
                            state_q     <= StRead;
                        end
                    end
                end
                StRead: begin
                    if (k_q == 2'd3) begin
                        mem_en  <= 1'b0;
                        state_q <= StCapt;
                    end else begin
                        k_q      <= k_q + 2'd1;
                        mem_addr <= base_q + ADDR_W'(k_q + 2'd1);
                    end
                end
                StCapt: begin
                    out_valid <= 1'b1;
                    state_q   <= StOut;
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        remaining_q <= remaining_q - 1'b1;
                        base_q      <= base_q + ADDR_W'(WORD_BYTES);
                        if (remaining_q == CNT_W'(1)) begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            k_q      <= 2'd0;
                            mem_en   <= 1'b1;
                            mem_addr <= base_q + ADDR_W'(WORD_BYTES);
                            state_q  <= StRead;
                        end
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
